// File: rtl/audio_codec_link.sv
// -----------------------------------------------------------------------------
// audio_codec_link
//
// Codec-side end of the APU sample interface. Generates the I2S bit clock and
// the LR clocks for a WM8731-class codec. Serialises the 16-bit mixed sample to
// the DAC as mono, sending the same word in both slots. Deserialises the
// left-channel ADC word back to the mixer.
//
// Ports
//   clk           system clock; the only clock in the block
//   reset         synchronous, active-high reset
//   audio_output  sample from the producer; latched one bclk period after
//                 sample_req
//   sample_req    one-clk pulse asking the producer for the next sample
//   audio_input   last captured left-channel ADC word; held between captures
//   sample_end    one-clk pulse; audio_input was just updated
//   aud_bclk      codec bit clock
//   aud_daclrck   DAC LR clock (0 = left slot, 1 = right slot)
//   aud_adclrck   ADC LR clock; always equal to aud_daclrck
//   aud_dacdat    serial DAC data, MSB first, one-bit I2S delay
//   aud_adcdat    serial ADC data, MSB first
// -----------------------------------------------------------------------------
module audio_codec_link #(
   parameter int BCLK_HALF    = 8,
   parameter int SLOT_BITS    = 32,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] audio_output,
   output logic                    sample_req,
   output logic [SAMPLE_WIDTH-1:0] audio_input,
   output logic                    sample_end,
   output logic                    aud_bclk,
   output logic                    aud_daclrck,
   output logic                    aud_adclrck,
   output logic                    aud_dacdat,
   input  logic                    aud_adcdat
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_TWO  = BIT_W'(2);
   localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] WIDTH_B  = BIT_W'(SAMPLE_WIDTH);

   logic [DIV_W-1:0]        div_cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic [SAMPLE_WIDTH-1:0] latched;
   logic [SAMPLE_WIDTH-1:0] dac_shift;
   logic [SAMPLE_WIDTH-1:0] adc_shift;
   logic                    adc_done;

   logic                    div_wrap;
   logic                    bclk_rise;
   logic                    bclk_fall;
   logic [BIT_W-1:0]        bit_next;
   logic                    right_next;
   logic [BIT_W-1:0]        slot_next;
   logic [SAMPLE_WIDTH-1:0] load_word;

   // Edge detection and frame position. All timing derives from the divider
   // wrap, so bclk edges are known one cycle early and every output changes
   // in the same cycle as aud_bclk. slot_next is the bit index within the
   // slot that the upcoming falling edge starts.
   always_comb begin
      div_wrap   = (div_cnt == DIV_LAST);
      bclk_rise  = div_wrap && !aud_bclk;
      bclk_fall  = div_wrap && aud_bclk;
      bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
      right_next = (bit_next >= SLOT_B);
      slot_next  = right_next ? bit_next - SLOT_B : bit_next;
      // The right slot reuses the word latched for the left slot (mono).
      load_word  = right_next ? latched : audio_output;
   end

   // Bit clock, frame counter, LR clock and sample request. bit_cnt resets to
   // the last frame bit so that the first falling edge opens bit 0 of a left
   // slot and issues the first sample_req.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt     <= '0;
         aud_bclk    <= 1'b0;
         bit_cnt     <= BIT_LAST;
         aud_daclrck <= 1'b0;
         sample_req  <= 1'b0;
      end else begin
         sample_req <= 1'b0;
         if (div_wrap) begin
            div_cnt  <= '0;
            aud_bclk <= !aud_bclk;
         end else begin
            div_cnt <= div_cnt + DIV_ONE;
         end
         if (bclk_fall) begin
            bit_cnt     <= bit_next;
            aud_daclrck <= right_next;
            sample_req  <= (bit_next == '0);
         end
      end
   end

   assign aud_adclrck = aud_daclrck;

   // DAC serialiser. Slot bit 0 is the I2S one-bit delay. At slot bit 1 the
   // word is loaded: its MSB goes straight to aud_dacdat, and the rest is
   // kept left-aligned in dac_shift. Each later falling edge up to bit
   // SAMPLE_WIDTH then emits the shift-register MSB. The remaining slot bits
   // are driven low.
   always_ff @(posedge clk) begin
      if (reset) begin
         latched    <= '0;
         dac_shift  <= '0;
         aud_dacdat <= 1'b0;
      end else if (bclk_fall) begin
         if (slot_next == BIT_ONE) begin
            if (!right_next) begin
               latched <= audio_output;
            end
            dac_shift  <= {load_word[SAMPLE_WIDTH-2:0], 1'b0};
            aud_dacdat <= load_word[SAMPLE_WIDTH-1];
         end else if (slot_next >= BIT_TWO && slot_next <= WIDTH_B) begin
            dac_shift  <= {dac_shift[SAMPLE_WIDTH-2:0], 1'b0};
            aud_dacdat <= dac_shift[SAMPLE_WIDTH-1];
         end else begin
            aud_dacdat <= 1'b0;
         end
      end
   end

   // ADC deserialiser. The data line is sampled on rising bclk in the middle
   // of each bit, during left-slot bits 1..SAMPLE_WIDTH only. bit_cnt still
   // holds the current bit here because it advances on falling edges.
   // adc_done marks the final bit; the word is published one clk later with
   // sample_end. A reset clears adc_done, so a partial word is never
   // published.
   always_ff @(posedge clk) begin
      if (reset) begin
         adc_shift   <= '0;
         adc_done    <= 1'b0;
         audio_input <= '0;
         sample_end  <= 1'b0;
      end else begin
         adc_done   <= 1'b0;
         sample_end <= adc_done;
         if (bclk_rise && bit_cnt >= BIT_ONE && bit_cnt <= WIDTH_B) begin
            adc_shift <= {adc_shift[SAMPLE_WIDTH-2:0], aud_adcdat};
            adc_done  <= (bit_cnt == WIDTH_B);
         end
         if (adc_done) begin
            audio_input <= adc_shift;
         end
      end
   end

endmodule

// File: tb/tb_audio_codec_link.sv
// -----------------------------------------------------------------------------
// tb_audio_codec_link
//
// Self-checking bench for audio_codec_link (BCLK_HALF=4, SLOT_BITS=32,
// SAMPLE_WIDTH=16). A reference model derives every output from the number of
// clks since reset release:
//   - bclk phase from t / BCLK_HALF;
//   - the frame bit from the count of falling edges;
//   - DAC bits from the word present at each left load;
//   - the ADC word from the bits present at each rising edge.
// A compare process checks all outputs on every cycle. Literal checks pin
// the startup timing, frame period, serial words and captured ADC words.
// -----------------------------------------------------------------------------
module tb_audio_codec_link;

   localparam int H          = 4;
   localparam int S          = 32;
   localparam int W          = 16;
   localparam int FRAME_CLKS = 2 * H * 2 * S;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] audio_output = 16'hA5C3;
   logic         aud_adcdat = 1'b0;
   logic         sample_req;
   logic [W-1:0] audio_input;
   logic         sample_end;
   logic         aud_bclk;
   logic         aud_daclrck;
   logic         aud_adclrck;
   logic         aud_dacdat;

   always #5 clk = ~clk;

   audio_codec_link #(
      .BCLK_HALF    (H),
      .SLOT_BITS    (S),
      .SAMPLE_WIDTH (W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .audio_output (audio_output),
      .sample_req   (sample_req),
      .audio_input  (audio_input),
      .sample_end   (sample_end),
      .aud_bclk     (aud_bclk),
      .aud_daclrck  (aud_daclrck),
      .aud_adclrck  (aud_adclrck),
      .aud_dacdat   (aud_dacdat),
      .aud_adcdat   (aud_adcdat)
   );

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit           m_valid = 1'b0;
   int           m_t = 0;
   int           m_f = 0;
   int           m_bc = 2 * S - 1;
   bit           m_fall = 1'b0;
   bit           m_rise = 1'b0;
   logic [W-1:0] frame_word = '0;
   logic [W-1:0] pend_word = '0;
   logic [W-1:0] exp_in = '0;
   int           adc_acc = 0;
   int           se_due = -1;
   bit           exp_se = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_valid    = 1'b1;
         m_t        = 0;
         frame_word = '0;
         pend_word  = '0;
         exp_in     = '0;
         adc_acc    = 0;
         se_due     = -1;
      end else if (m_valid) begin
         m_t++;
      end
      m_f    = m_t / (2 * H);
      m_bc   = (m_f + 2 * S - 1) % (2 * S);
      m_fall = !reset && m_valid && m_t > 0 && (m_t % (2 * H)) == 0;
      m_rise = !reset && m_valid && (m_t % (2 * H)) == H;
      if (m_fall && m_bc == 1) frame_word = audio_output;
      if (m_rise && m_bc >= 1 && m_bc <= W) begin
         adc_acc = ((adc_acc << 1) | int'(aud_adcdat)) & 32'hFFFF;
         if (m_bc == W) begin
            pend_word = W'(adc_acc);
            se_due    = m_t + 1;
         end
      end
      exp_se = !reset && m_valid && (m_t == se_due);
      if (exp_se) exp_in = pend_word;
   end

   int   exp_s;
   logic exp_lr;
   logic exp_dac;

   always @(negedge clk) begin
      if (m_valid) begin
         exp_s   = m_bc % S;
         exp_lr  = (m_f >= 1) && (m_bc >= S);
         exp_dac = (m_f >= 1 && exp_s >= 1 && exp_s <= W) ? frame_word[W - exp_s] : 1'b0;
         checkOutput("bclk", 32'(aud_bclk), 32'((m_t / H) % 2));
         checkOutput("daclrck", 32'(aud_daclrck), 32'(exp_lr));
         checkOutput("adclrck", 32'(aud_adclrck), 32'(exp_lr));
         checkOutput("sample_req", 32'(sample_req), 32'(m_fall && m_bc == 0));
         checkOutput("dacdat", 32'(aud_dacdat), 32'(exp_dac));
         checkOutput("sample_end", 32'(sample_end), 32'(exp_se));
         checkOutput("audio_input", 32'(audio_input), 32'(exp_in));
      end
   end

   // ---------------- ADC source: changes data just after falling bclk -------
   bit           adc_random = 1'b0;
   logic [W-1:0] adc_left = 16'h8001;

   always @(posedge clk) begin
      #1;
      if (m_fall) begin
         if (m_bc == 0 && adc_random) adc_left = W'($urandom);
         if (m_bc >= 1 && m_bc <= W)
            aud_adcdat = adc_left[W - m_bc];
         else if (m_bc >= S && !adc_random)
            aud_adcdat = 1'b1;
         else
            aud_adcdat = 1'($urandom_range(1));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applyReset(input int cycles);
      @(negedge clk);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   // Called at the negedge where reset has just been released (t = 0).
   // Returns at t = 8, the negedge carrying the first sample_req.
   task automatic checkStartup();
      checkOutput("rst_bclk", 32'(aud_bclk), 32'd0);
      checkOutput("rst_req", 32'(sample_req), 32'd0);
      checkOutput("rst_lrck", 32'(aud_daclrck), 32'd0);
      checkOutput("rst_dacdat", 32'(aud_dacdat), 32'd0);
      checkOutput("rst_end", 32'(sample_end), 32'd0);
      checkOutput("rst_audio_input", 32'(audio_input), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 3) checkOutput("bclk_before_rise", 32'(aud_bclk), 32'd0);
         if (k == 4) checkOutput("bclk_rise_clk4", 32'(aud_bclk), 32'd1);
         if (k == 7) checkOutput("req_before_clk8", 32'(sample_req), 32'd0);
         if (k == 8) begin
            checkOutput("bclk_fall_clk8", 32'(aud_bclk), 32'd0);
            checkOutput("req_clk8", 32'(sample_req), 32'd1);
            checkOutput("lrck_clk8", 32'(aud_daclrck), 32'd0);
         end
      end
   endtask

   // Starts at a negedge showing sample_req and runs one whole frame. It
   // samples aud_dacdat mid-bit and optionally changes audio_output at clk
   // change_k. It ends on the negedge where the next sample_req must appear.
   task automatic captureFrame(input logic [W-1:0] later_val, input int change_k,
                               output logic [W-1:0] left, output logic [W-1:0] right,
                               output int zero_errs, output int se_cnt);
      int b;
      int s;
      left      = '0;
      right     = '0;
      zero_errs = 0;
      se_cnt    = 0;
      for (int k = 0; k < FRAME_CLKS; k++) begin
         if (k == change_k) audio_output = later_val;
         if (k % (2 * H) == H) begin
            b = k / (2 * H);
            s = b % S;
            if (s >= 1 && s <= W) begin
               if (b < S) left[W - s] = aud_dacdat;
               else       right[W - s] = aud_dacdat;
            end else if (aud_dacdat !== 1'b0) begin
               zero_errs++;
            end
         end
         if (sample_end) se_cnt++;
         if (k == FRAME_CLKS / 2 - 1) checkOutput("lrck_left_end", 32'(aud_daclrck), 32'd0);
         if (k == FRAME_CLKS / 2)     checkOutput("lrck_right_start", 32'(aud_daclrck), 32'd1);
         @(negedge clk);
      end
      checkOutput("frame_period_req", 32'(sample_req), 32'd1);
   endtask

   logic [W-1:0] left_w;
   logic [W-1:0] right_w;
   int           zero_errs;
   int           se_cnt;

   initial begin
      // Reset release and startup timing.
      audio_output = 16'hA5C3;
      applyReset(3);
      checkStartup();

      // DAC serialisation of a held word, with the ADC pattern running.
      for (int f = 0; f < 3; f++) begin
         captureFrame('0, -1, left_w, right_w, zero_errs, se_cnt);
         checkOutput("dac_left_A5C3", 32'(left_w), 32'hA5C3);
         checkOutput("dac_right_A5C3", 32'(right_w), 32'hA5C3);
         checkOutput("dac_idle_bits_zero", 32'(zero_errs), 32'd0);
         checkOutput("one_sample_end_per_frame", 32'(se_cnt), 32'd1);
         checkOutput("adc_word_8001", 32'(audio_input), 32'h8001);
      end

      // Mono latch: the word changes after the left load.
      audio_output = 16'h1234;
      captureFrame(16'hFFFF, 2 * H + 2, left_w, right_w, zero_errs, se_cnt);
      checkOutput("mono_left_1234", 32'(left_w), 32'h1234);
      checkOutput("mono_right_1234", 32'(right_w), 32'h1234);
      captureFrame('0, -1, left_w, right_w, zero_errs, se_cnt);
      checkOutput("next_frame_left_FFFF", 32'(left_w), 32'hFFFF);
      checkOutput("next_frame_right_FFFF", 32'(right_w), 32'hFFFF);

      // Reset during left bit 10 of an ADC capture.
      applyStimulus(10 * 2 * H + 1);
      applyReset(1);
      checkOutput("midreset_audio_input", 32'(audio_input), 32'd0);
      checkStartup();
      captureFrame('0, -1, left_w, right_w, zero_errs, se_cnt);
      checkOutput("post_reset_left", 32'(left_w), 32'hFFFF);
      checkOutput("post_reset_adc", 32'(audio_input), 32'h8001);

      // Randomised words and ADC data, checked by the model.
      adc_random = 1'b1;
      for (int f = 0; f < 6; f++) begin
         captureFrame(W'($urandom), $urandom_range(FRAME_CLKS - 1),
                      left_w, right_w, zero_errs, se_cnt);
         checkOutput("rand_one_sample_end", 32'(se_cnt), 32'd1);
      end
      applyStimulus($urandom_range(FRAME_CLKS - 1));
      applyReset($urandom_range(3, 1));
      checkStartup();
      for (int f = 0; f < 2; f++) begin
         captureFrame(W'($urandom), $urandom_range(FRAME_CLKS - 1),
                      left_w, right_w, zero_errs, se_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
